cu_sequencer: RTL and testbench

Parametrised instruction sequencer for the TPU control unit. It takes 16-bit instruction words through a valid/ready stream, decodes them and issues arithmetic operations to a DATA_THREADS-wide lane array. Each operation waits for completion from every enabled lane before the next one issues. The block adds a hardware repeat (LOOP), halt/error reporting and an issue counter, and sits between the instruction source and the FPU lanes.

---
 rtl/cu_sequencer_pkg.sv | 48 ++++
 rtl/cu_sequencer_if.sv | 31 +++
 rtl/cu_sequencer_decoder.sv | 36 +++
 rtl/cu_sequencer.sv | 143 ++++++++++++++
 tb/tb_cu_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cu_sequencer_pkg.sv
// Shared types for the TPU control-unit sequencer: opcodes, FSM states,
// instruction layout and the latched operation fields.
package cu_pkg;

  localparam int INSTR_WIDTH = 16;

  typedef enum logic [3:0] {
    OPC_NOP  = 4'd0,
    OPC_ADD  = 4'd1,
    OPC_SUB  = 4'd2,
    OPC_MUL  = 4'd3,
    OPC_DIV  = 4'd4,
    OPC_LOOP = 4'd5,
    OPC_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_HALT,
    ST_ERROR
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LOOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] dst;
    logic [3:0] src_a;
    logic [3:0] src_b;
  } instr_t;

  typedef struct packed {
    logic [2:0] code;
    logic [3:0] dst;
    logic [3:0] src_a;
    logic [3:0] src_b;
  } op_fields_t;

endpackage

// File: rtl/cu_sequencer_if.sv
// Instruction stream plus lane operation bus between the sequencer (master)
// and the instruction source / FPU lanes (slave).
interface cu_sequencer_if #(
  parameter int DATA_THREADS = 2
);
  import cu_pkg::*;

  logic                    instr_valid;
  logic                    instr_ready;
  logic [INSTR_WIDTH-1:0]  instr;
  logic [DATA_THREADS-1:0] lane_enable;
  logic                    op_valid;
  logic                    op_ready;
  logic [2:0]              op_code;
  logic [3:0]              op_dst;
  logic [3:0]              op_src_a;
  logic [3:0]              op_src_b;
  logic [DATA_THREADS-1:0] op_lane_mask;
  logic [DATA_THREADS-1:0] lane_done;

  modport master (
    input  instr_valid, instr, lane_enable, op_ready, lane_done,
    output instr_ready, op_valid, op_code, op_dst, op_src_a, op_src_b, op_lane_mask
  );

  modport slave (
    output instr_valid, instr, lane_enable, op_ready, lane_done,
    input  instr_ready, op_valid, op_code, op_dst, op_src_a, op_src_b, op_lane_mask
  );

endinterface

// File: rtl/cu_sequencer_decoder.sv
// Combinational instruction decoder: classifies the opcode and splits out
// register fields and the LOOP immediate.
module cu_decoder
  import cu_pkg::*;
(
  input  instr_t     instr,
  output op_class_e  op_class,
  output logic [2:0] alu_code,
  output logic [3:0] dst,
  output logic [3:0] src_a,
  output logic [3:0] src_b,
  output logic [7:0] imm,
  output logic       illegal
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_code = '0;
    dst      = instr.dst;
    src_a    = instr.src_a;
    src_b    = instr.src_b;
    imm      = {instr.src_a, instr.src_b};
    case (instr.opcode)
      OPC_NOP:  op_class = CLS_NOP;
      OPC_ADD, OPC_SUB, OPC_MUL, OPC_DIV: begin
        op_class = CLS_ALU;
        alu_code = instr.opcode[2:0];
      end
      OPC_LOOP: op_class = CLS_LOOP;
      OPC_HALT: op_class = CLS_HALT;
      default:  op_class = CLS_ILLEGAL;
    endcase
    illegal = (op_class == CLS_ILLEGAL);
  end

endmodule

// File: rtl/cu_sequencer.sv
// Instruction sequencer: fetches words, issues ALU ops to the lane array and
// waits for every enabled lane to complete, with hardware repeat and halt.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int BITNESS      = 32,
  parameter int DATA_THREADS = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  cu_sequencer_if.master         bus,
  output logic                   busy,
  output logic                   halted,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] issued_count
);

  // Lane width is only carried for lane sizing; reject nonsense values early.
  if (BITNESS < 1) begin : g_bitness_check
    $error("cu_sequencer: BITNESS must be positive");
  end

  state_e                  state, state_n;
  logic [DATA_THREADS-1:0] pending, pending_n;
  logic [7:0]              repeat_cnt, repeat_n;
  logic [COUNT_WIDTH-1:0]  count_q, count_n;
  op_fields_t              fields_q, fields_n;

  op_class_e  dec_class;
  logic [2:0] dec_code;
  logic [3:0] dec_dst, dec_src_a, dec_src_b;
  logic [7:0] dec_imm;
  logic       dec_illegal;
  logic [DATA_THREADS-1:0] remaining;

  cu_decoder u_decoder (
    .instr    (instr_t'(bus.instr)),
    .op_class (dec_class),
    .alu_code (dec_code),
    .dst      (dec_dst),
    .src_a    (dec_src_a),
    .src_b    (dec_src_b),
    .imm      (dec_imm),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pending    <= '0;
      repeat_cnt <= '0;
      count_q    <= '0;
      fields_q   <= '0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      repeat_cnt <= repeat_n;
      count_q    <= count_n;
      fields_q   <= fields_n;
    end
  end

  assign remaining = pending & ~bus.lane_done;

  always_comb begin
    state_n   = state;
    pending_n = pending;
    repeat_n  = repeat_cnt;
    count_n   = count_q;
    fields_n  = fields_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_FETCH;
          count_n  = '0;
          repeat_n = '0;
        end
      end
      ST_FETCH: begin
        if (bus.instr_valid) begin
          if (dec_illegal) begin
            state_n = ST_ERROR;
          end else begin
            case (dec_class)
              CLS_NOP:  repeat_n = '0;
              CLS_LOOP: repeat_n = dec_imm;
              CLS_HALT: begin
                state_n  = ST_HALT;
                repeat_n = '0;
              end
              CLS_ALU: begin
                state_n  = ST_ISSUE;
                fields_n = '{code: dec_code, dst: dec_dst, src_a: dec_src_a, src_b: dec_src_b};
              end
              default: state_n = ST_ERROR;
            endcase
          end
        end
      end
      ST_ISSUE: begin
        if (bus.op_ready) begin
          pending_n = bus.lane_enable;
          count_n   = count_q + COUNT_WIDTH'(1);
          state_n   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completions for lanes that are not pending fall out of the mask.
        pending_n = remaining;
        if (remaining == '0) begin
          if (repeat_cnt != 8'd0) begin
            repeat_n = repeat_cnt - 8'd1;
            state_n  = ST_ISSUE;
          end else begin
            state_n = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        if (start) begin
          state_n = ST_FETCH;
          count_n = '0;
        end
      end
      default: state_n = ST_ERROR;
    endcase
  end

  assign bus.instr_ready  = (state == ST_FETCH);
  assign bus.op_valid     = (state == ST_ISSUE);
  assign bus.op_code      = fields_q.code;
  assign bus.op_dst       = fields_q.dst;
  assign bus.op_src_a     = fields_q.src_a;
  assign bus.op_src_b     = fields_q.src_b;
  assign bus.op_lane_mask = (state == ST_ISSUE) ? bus.lane_enable : '0;
  assign busy             = (state == ST_FETCH) || (state == ST_ISSUE) || (state == ST_WAIT);
  assign halted           = (state == ST_HALT);
  assign error            = (state == ST_ERROR);
  assign issued_count     = count_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Randomised directed bench for cu_sequencer against a program-level model:
// each ALU word yields repeat+1 identical ops and a modulo-16 issue count.
module tb_cu_sequencer;

  localparam int DT = 2;
  localparam int CW = 4;

  logic          clock = 0;
  logic          reset;
  logic          start;
  logic          busy, halted, error;
  logic [CW-1:0] issued_count;

  int n_cmp = 0;
  int n_fail = 0;
  int model_count = 0;
  int model_rep = 0;
  int le_mode = 0;

  cu_sequencer_if #(.DATA_THREADS(DT)) bus ();

  cu_sequencer #(.BITNESS(32), .DATA_THREADS(DT), .COUNT_WIDTH(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .halted       (halted),
    .error        (error),
    .issued_count (issued_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  // One operation from offer to completion, with random stall and lane timing.
  task automatic do_op(input logic [2:0] code, input logic [3:0] d, input logic [3:0] a,
                       input logic [3:0] b, input bit more);
    int delay;
    int t_last;
    int sched [DT];
    logic [DT-1:0] le;
    logic [DT-1:0] done;
    check_output("op_valid", bus.op_valid, 1);
    delay = (le_mode == 0) ? $urandom_range(0, 3) : 0;
    for (int i = 0; i <= delay; i++) begin
      le = (le_mode == 1) ? '0 : (le_mode == 2) ? '1 : DT'($urandom);
      bus.lane_enable = le;
      bus.lane_done   = DT'($urandom);
      bus.op_ready    = (i == delay);
      #1;
      check_output("op_code", bus.op_code, code);
      check_output("op_dst", bus.op_dst, d);
      check_output("op_src_a", bus.op_src_a, a);
      check_output("op_src_b", bus.op_src_b, b);
      check_output("op_lane_mask", bus.op_lane_mask, le);
      step();
    end
    bus.op_ready = 0;
    model_count++;
    check_output("issued_count", issued_count, model_count % 16);
    check_output("op_valid_wait", bus.op_valid, 0);
    t_last = 0;
    for (int j = 0; j < DT; j++) begin
      sched[j] = le[j] ? ((le_mode == 2) ? 0 : $urandom_range(0, 2)) : -1;
      if (sched[j] > t_last) t_last = sched[j];
    end
    for (int t = 0; t <= t_last; t++) begin
      for (int j = 0; j < DT; j++) begin
        if (sched[j] == t) done[j] = 1'b1;
        else if (sched[j] < t) done[j] = 1'($urandom_range(0, 1));
        else done[j] = 1'b0;
      end
      bus.lane_done = done;
      #1;
      check_output("wait_status", {bus.instr_ready, bus.op_valid, busy}, 3'b001);
      step();
    end
    bus.lane_done = '0;
    check_output("after_wait_op_valid", bus.op_valid, more);
    check_output("after_wait_instr_ready", bus.instr_ready, !more);
  endtask

  // Presents one word and follows it through according to the program model.
  task automatic apply_stimulus(input logic [15:0] w);
    int idle;
    int reps;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      bus.instr_valid = 0;
      bus.instr = 16'($urandom);
      step();
    end
    check_output("instr_ready", bus.instr_ready, 1);
    bus.instr_valid = 1;
    bus.instr = w;
    step();
    bus.instr_valid = 0;
    bus.instr = 16'($urandom);
    case (int'(w[15:12]))
      0: begin
        model_rep = 0;
        check_output("nop_fetch", bus.instr_ready, 1);
      end
      1, 2, 3, 4: begin
        reps = model_rep;
        model_rep = 0;
        for (int k = 0; k <= reps; k++)
          do_op(w[14:12], w[11:8], w[7:4], w[3:0], k < reps);
      end
      5: begin
        model_rep = int'(w[7:0]);
        check_output("loop_fetch", bus.instr_ready, 1);
      end
      15: begin
        model_rep = 0;
        check_output("halted", halted, 1);
        check_output("halt_busy", busy, 0);
      end
      default: begin
        check_output("error", error, 1);
        check_output("error_busy", busy, 0);
      end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check_output(tag, {bus.instr_ready, bus.op_valid, busy, halted, error, issued_count,
                       bus.op_code, bus.op_dst, bus.op_src_a, bus.op_src_b, bus.op_lane_mask}, 0);
  endtask

  initial begin
    logic [15:0] w;
    reset = 0;
    start = 0;
    bus.instr_valid = 0;
    bus.instr = '0;
    bus.lane_enable = '0;
    bus.op_ready = 0;
    bus.lane_done = '0;
    step();
    step();
    check_all_zero("reset_outputs");
    reset = 1;
    step();
    check_all_zero("idle_outputs");

    pulse_start();
    check_output("start_busy", busy, 1);
    le_mode = 2;
    apply_stimulus(16'h1123);
    le_mode = 0;
    apply_stimulus(16'h5003);
    apply_stimulus(16'h3456);
    check_output("loop_count", issued_count, 5);

    // NOP cancels a pending repeat; a second LOOP overwrites the first.
    apply_stimulus(16'h5002);
    apply_stimulus(16'h0000);
    apply_stimulus(16'h2abc);
    apply_stimulus(16'h5007);
    apply_stimulus(16'h5001);
    apply_stimulus(16'h4def);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0: w = 16'h0000;
        1: w = {8'h50, 6'd0, 2'($urandom)};
        default: w = {1'b0, 3'($urandom_range(1, 4)), 12'($urandom)};
      endcase
      apply_stimulus(w);
    end

    le_mode = 1;
    apply_stimulus(16'h1111);
    le_mode = 2;
    apply_stimulus(16'h2222);
    le_mode = 0;

    apply_stimulus(16'hf000);
    pulse_start();
    model_count = 0;
    check_output("restart_count", issued_count, 0);
    check_output("restart_ready", bus.instr_ready, 1);
    check_output("restart_halted", halted, 0);

    bus.instr_valid = 1;
    bus.instr = 16'h2789;
    step();
    bus.instr_valid = 0;
    bus.lane_enable = '1;
    bus.op_ready = 1;
    step();
    bus.op_ready = 0;
    check_output("pre_reset_busy", busy, 1);
    reset = 0;
    step();
    reset = 1;
    check_all_zero("reset_in_wait");
    step();
    check_all_zero("idle_after_reset");

    pulse_start();
    model_count = 0;
    model_rep = 0;
    apply_stimulus(16'h9abc);
    pulse_start();
    check_output("error_sticky", error, 1);
    check_output("error_no_fetch", bus.instr_ready, 0);
    reset = 0;
    step();
    reset = 1;
    check_output("error_cleared", error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
